// File: rtl/taxi_dispatch_ctrl.sv
// Taxi dispatch: round-robin seat boarding, trip FSM and meter tick; VIP hire is built only with TAXI_DISPATCH_VIP_EN.
// All outputs registered (one-cycle latency from inputs); no backpressure, requests that cannot be served are dropped, not queued.
module taxi_dispatch_ctrl #(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] board_req,
    input  logic [3:0] alight_req,
    input  logic       vip_req,
    input  logic       vip_end,
    input  logic       go,
    input  logic       shift_end,
    output logic [3:0] seat_occ,
    output logic [3:0] board_gnt,
    output logic [2:0] occ_count,
    output logic       vip_enable,
    output logic       moving,
    output logic       meter_tick,
    output logic       reset_income
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

`ifdef TAXI_DISPATCH_VIP_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHARED    = 3'd1,
        ST_VIP       = 3'd2,
        ST_VIP_DRAIN = 3'd3,
        ST_CLEAR     = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHARED = 3'd1,
        ST_CLEAR  = 3'd4
    } state_t;
    logic unused_vip;
    assign unused_vip = vip_req ^ vip_end;
`endif

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    seat_occ_q, seat_occ_d;
    logic [3:0]    board_gnt_q, board_gnt_d;
    logic [2:0]    occ_count_q, occ_count_d;
    logic          vip_enable_q, vip_enable_d;
    logic          moving_q, moving_d;
    logic          meter_tick_q, meter_tick_d;
    logic          reset_income_q, reset_income_d;

    logic [3:0]    alight_acc;
    logic [3:0]    elig;
    logic [1:0]    idx;
    logic          vip_go;
    logic          board_ok;
    logic          found;
    logic          counting;
    logic          next_in_trip;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cnt_d          = '0;
        board_gnt_d    = '0;
        alight_acc     = '0;
        idx            = '0;
        found          = 1'b0;
        vip_go         = 1'b0;
        counting       = 1'b0;
        next_in_trip   = 1'b0;
        meter_tick_d   = 1'b0;
        occ_count_d    = '0;

`ifdef TAXI_DISPATCH_VIP_EN
        vip_go = (state_q == ST_IDLE) && vip_req;
`endif
        if (state_q == ST_SHARED) begin
            alight_acc = alight_req & seat_occ_q;
        end

        // An alight on a seat masks that seat's board request in the same cycle.
        board_ok = (state_q == ST_SHARED) ||
                   ((state_q == ST_IDLE) && !vip_go && !shift_end);
        elig     = board_req & ~seat_occ_q & ~alight_req;

        if (board_ok && (seat_occ_q != 4'hF)) begin
            for (int k = 0; k < 4; k++) begin
                idx = ptr_q + 2'(k);
                if (!found && elig[idx]) begin
                    found            = 1'b1;
                    board_gnt_d[idx] = 1'b1;
                    ptr_d            = idx + 2'd1;
                end
            end
        end

        seat_occ_d = (seat_occ_q & ~alight_acc) | board_gnt_d;
        for (int i = 0; i < 4; i++) begin
            occ_count_d = occ_count_d + {2'b00, seat_occ_d[i]};
        end

        case (state_q)
            ST_IDLE: begin
                if (vip_go)                state_d = state_t'(3'd2);
                else if (shift_end)        state_d = ST_CLEAR;
                else if (board_gnt_d != 0) state_d = ST_SHARED;
            end
            ST_SHARED: begin
                if (seat_occ_d == 4'h0)    state_d = ST_IDLE;
            end
`ifdef TAXI_DISPATCH_VIP_EN
            ST_VIP: begin
                counting = 1'b1;
                if (vip_end)               state_d = ST_VIP_DRAIN;
            end
            ST_VIP_DRAIN:                  state_d = ST_IDLE;
`endif
            ST_CLEAR:                      state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase

        if (state_q == ST_SHARED) counting = 1'b1;
        if (counting) begin
            cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
            meter_tick_d = (cnt_q == CNT_MAX);
        end

        // Output flags track the state being entered so they line up with state_q.
`ifdef TAXI_DISPATCH_VIP_EN
        vip_enable_d = (state_d == ST_VIP);
        next_in_trip = (state_d == ST_SHARED) || (state_d == ST_VIP);
`else
        vip_enable_d = 1'b0;
        next_in_trip = (state_d == ST_SHARED);
`endif
        moving_d       = next_in_trip && go && (board_gnt_d == 4'h0) && (alight_acc == 4'h0);
        reset_income_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            cnt_q          <= '0;
            seat_occ_q     <= '0;
            board_gnt_q    <= '0;
            occ_count_q    <= '0;
            vip_enable_q   <= 1'b0;
            moving_q       <= 1'b0;
            meter_tick_q   <= 1'b0;
            reset_income_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            seat_occ_q     <= seat_occ_d;
            board_gnt_q    <= board_gnt_d;
            occ_count_q    <= occ_count_d;
            vip_enable_q   <= vip_enable_d;
            moving_q       <= moving_d;
            meter_tick_q   <= meter_tick_d;
            reset_income_q <= reset_income_d;
        end
    end

    assign seat_occ     = seat_occ_q;
    assign board_gnt    = board_gnt_q;
    assign occ_count    = occ_count_q;
    assign vip_enable   = vip_enable_q;
    assign moving       = moving_q;
    assign meter_tick   = meter_tick_q;
    assign reset_income = reset_income_q;

endmodule

// File: tb/tb_taxi_dispatch_ctrl.sv
// Random and directed stimulus for taxi_dispatch_ctrl, checked against a trip-level reference model.
module tb_taxi_dispatch_ctrl;

    localparam int TD = 4;
    localparam int M_IDLE = 0, M_SHARED = 1, M_VIP = 2, M_DRAIN = 3, M_CLEAR = 4;
`ifdef TAXI_DISPATCH_VIP_EN
    localparam bit VIP_BUILT = 1'b1;
`else
    localparam bit VIP_BUILT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] board_req, alight_req;
    logic       vip_req, vip_end, go, shift_end;
    logic [3:0] seat_occ, board_gnt;
    logic [2:0] occ_count;
    logic       vip_enable, moving, meter_tick, reset_income;

    int n_vec = 0;
    int n_bad = 0;

    int       m_st, m_ptr, m_cnt;
    bit [3:0] m_occ, m_gnt;
    bit       m_tick, m_mov, m_vip, m_ri;

    taxi_dispatch_ctrl #(.TICK_DIV(TD)) dut (
        .clock(clock), .reset_n(reset_n), .board_req(board_req), .alight_req(alight_req),
        .vip_req(vip_req), .vip_end(vip_end), .go(go), .shift_end(shift_end),
        .seat_occ(seat_occ), .board_gnt(board_gnt), .occ_count(occ_count),
        .vip_enable(vip_enable), .moving(moving), .meter_tick(meter_tick),
        .reset_income(reset_income)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a taxi with four seats, a trip state and a meter that ticks every TD cycles.
    task automatic model_step();
        bit [3:0] acc;
        int       nxt;
        bit       vip_take, may_board, in_trip;
        if (!reset_n) begin
            m_st = M_IDLE; m_ptr = 0; m_cnt = 0; m_occ = 0; m_gnt = 0;
            m_tick = 0; m_mov = 0; m_vip = 0; m_ri = 0;
            return;
        end
        acc       = (m_st == M_SHARED) ? (alight_req & m_occ) : 4'h0;
        vip_take  = VIP_BUILT && (m_st == M_IDLE) && vip_req;
        may_board = (m_st == M_SHARED) || (m_st == M_IDLE && !vip_take && !shift_end);
        m_gnt = 0;
        if (may_board && $countones(m_occ) < 4) begin
            for (int k = 0; k < 4; k++) begin
                int s;
                s = (m_ptr + k) % 4;
                if (board_req[s] && !m_occ[s] && !alight_req[s]) begin
                    m_gnt = 4'(1 << s);
                    m_ptr = (s + 1) % 4;
                    break;
                end
            end
        end
        m_occ = (m_occ & ~acc) | m_gnt;
        nxt = m_st;
        case (m_st)
            M_IDLE:   if (vip_take) nxt = M_VIP; else if (shift_end) nxt = M_CLEAR;
                      else if (m_gnt != 0) nxt = M_SHARED;
            M_SHARED: if (m_occ == 0) nxt = M_IDLE;
            M_VIP:    if (vip_end) nxt = M_DRAIN;
            default:  nxt = M_IDLE;
        endcase
        in_trip = (m_st == M_SHARED) || (m_st == M_VIP);
        m_tick  = in_trip && (m_cnt == TD - 1);
        m_cnt   = in_trip ? (m_cnt + 1) % TD : 0;
        m_mov   = (nxt == M_SHARED || nxt == M_VIP) && go && m_gnt == 0 && acc == 0;
        m_vip   = (nxt == M_VIP);
        m_ri    = (nxt == M_CLEAR);
        m_st    = nxt;
    endtask

    task automatic step(input bit rn, input logic [3:0] b, input logic [3:0] a,
                        input bit vr, input bit ve, input bit g, input bit se);
        @(negedge clock);
        reset_n = rn; board_req = b; alight_req = a;
        vip_req = vr; vip_end = ve; go = g; shift_end = se;
        @(posedge clock);
        model_step();
        #1;
        chk("seat_occ", 32'(seat_occ), 32'(m_occ));
        chk("board_gnt", 32'(board_gnt), 32'(m_gnt));
        chk("occ_count", 32'(occ_count), 32'($countones(m_occ)));
        chk("vip_enable", 32'(vip_enable), 32'(m_vip));
        chk("moving", 32'(moving), 32'(m_mov));
        chk("meter_tick", 32'(meter_tick), 32'(m_tick));
        chk("reset_income", 32'(reset_income), 32'(m_ri));
    endtask

    initial begin
        int ticks;
        reset_n = 1'b0; board_req = '0; alight_req = '0;
        vip_req = 1'b0; vip_end = 1'b0; go = 1'b0; shift_end = 1'b0;

        // Reset state
        step(0, 4'h0, 4'h0, 1, 1, 1, 1);
        step(0, 4'hF, 4'h0, 1, 0, 1, 1);
        chk("rst_outputs", {seat_occ, board_gnt, occ_count, vip_enable, moving, meter_tick, reset_income}, 32'h0);

        // Round-robin fill of all four seats
        for (int i = 0; i < 4; i++) begin
            step(1, 4'hF, 4'h0, 0, 0, 0, 0);
            chk("rr_gnt", 32'(board_gnt), 32'(1 << i));
        end
        chk("full_occ", 32'(seat_occ), 32'hF);
        chk("full_cnt", 32'(occ_count), 32'd4);
        step(1, 4'hF, 4'h0, 0, 0, 0, 0);
        chk("full_nognt", 32'(board_gnt), 32'h0);

        // Meter with only seat 2 aboard
        step(1, 4'h0, 4'b1011, 0, 0, 0, 0);
        chk("alight_occ", 32'(seat_occ), 32'h4);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 4'h0, 4'h0, 0, 0, 1, 0);
            ticks += int'(meter_tick);
            chk("mov_run", 32'(moving), 32'h1);
        end
        chk("tick_count", 32'(ticks), 32'd3);

        // Alight beats board on the same seat
        step(1, 4'b0001, 4'h0, 0, 0, 0, 0);
        chk("occ_0101", 32'(seat_occ), 32'h5);
        step(1, 4'b0100, 4'b0100, 0, 0, 0, 0);
        chk("collide_occ", 32'(seat_occ), 32'h1);
        chk("collide_gnt", 32'(board_gnt), 32'h0);

        // shift_end ignored mid-trip, honoured in IDLE for one cycle
        step(1, 4'h0, 4'h0, 0, 0, 0, 1);
        chk("shared_noclr", 32'(reset_income), 32'h0);
        step(1, 4'h0, 4'b0001, 0, 0, 0, 0);
        chk("empty_occ", 32'(seat_occ), 32'h0);
        step(1, 4'h0, 4'h0, 0, 0, 0, 1);
        chk("clr_pulse", 32'(reset_income), 32'h1);
        step(1, 4'b0001, 4'h0, 0, 0, 0, 0);
        chk("clr_end", 32'(reset_income), 32'h0);
        chk("clr_nognt", 32'(board_gnt), 32'h0);

        // VIP request against board and shift_end in IDLE
`ifdef TAXI_DISPATCH_VIP_EN
        step(1, 4'b0001, 4'h0, 1, 0, 0, 1);
        chk("vip_on", 32'(vip_enable), 32'h1);
        chk("vip_nognt", 32'(board_gnt), 32'h0);
        chk("vip_noclr", 32'(reset_income), 32'h0);
        step(1, 4'h0, 4'h0, 0, 1, 0, 0);
        chk("vip_drain", 32'(vip_enable), 32'h0);
        step(1, 4'b0001, 4'h0, 0, 0, 0, 0);
        chk("drain_nognt", 32'(board_gnt), 32'h0);
        step(1, 4'b0001, 4'h0, 0, 0, 0, 0);
        chk("post_vip_gnt", 32'(board_gnt), 32'h1);
`else
        step(1, 4'b0001, 4'h0, 1, 0, 0, 0);
        chk("novip_gnt", 32'(board_gnt), 32'h1);
        chk("novip_en", 32'(vip_enable), 32'h0);
`endif
        step(1, 4'h0, 4'b0001, 0, 0, 0, 0);
        chk("vip_empty", 32'(seat_occ), 32'h0);

        // Reset mid-trip discards seats silently
        step(0, 4'h0, 4'h0, 0, 0, 0, 0);
        step(1, 4'b0011, 4'h0, 0, 0, 0, 0);
        step(1, 4'b0011, 4'h0, 0, 0, 0, 0);
        chk("trip_occ", 32'(seat_occ), 32'h3);
        step(1, 4'h0, 4'h0, 0, 0, 1, 0);
        chk("trip_mov", 32'(moving), 32'h1);
        step(0, 4'hF, 4'hF, 1, 1, 1, 1);
        chk("rst_mid", {seat_occ, board_gnt, occ_count, vip_enable, moving, meter_tick, reset_income}, 32'h0);
        step(1, 4'h0, 4'h0, 0, 0, 0, 0);
        chk("rst_noclr", 32'(reset_income), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          rn;
            logic [3:0]  b, a;
            rn = ($urandom_range(0, 99) != 0);
            b  = 4'($urandom_range(0, 15)) & (($urandom_range(0, 1) == 1) ? 4'hF : 4'h0);
            a  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            step(rn, b, a, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
